// File: rtl/cordic_ln_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_ln_ctrl_pkg
// Description : Shared types and codes for the ln-CORDIC control FSM:
//               state encoding, adder-call handshake states, operand-pair
//               and XYZ select codes, and the Moore output decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_ln_ctrl_pkg;

   // Main sequencer states
   typedef enum logic [4:0] {
      ST_IDLE   = 5'd0,
      ST_CLR    = 5'd1,
      ST_LOAD_T = 5'd2,
      ST_XINIT  = 5'd3,
      ST_YINIT  = 5'd4,
      ST_ZINIT  = 5'd5,
      ST_SETTLE = 5'd6,
      ST_SHIFT  = 5'd7,
      ST_XSEL   = 5'd8,
      ST_XUPD   = 5'd9,
      ST_YSEL   = 5'd10,
      ST_YUPD   = 5'd11,
      ST_ZSEL   = 5'd12,
      ST_ZUPD   = 5'd13,
      ST_STEP   = 5'd14,
      ST_FINAL  = 5'd15,
      ST_DONE   = 5'd16
   } state_t;

   // Adder-call handshake states
   typedef enum logic [1:0] {
      CS_IDLE  = 2'd0,
      CS_GO    = 2'd1,
      CS_WAIT  = 2'd2,
      CS_DRAIN = 2'd3
   } call_state_t;

   // Adder operand pair select (MS_4)
   localparam logic [1:0] PAIR_ZLN16 = 2'd0;
   localparam logic [1:0] PAIR_ITER  = 2'd1;
   localparam logic [1:0] PAIR_INIT  = 2'd2;

   // XYZ select codes (MS_2 / MS_3)
   localparam logic [1:0] SEL_Z = 2'd0;
   localparam logic [1:0] SEL_Y = 2'd1;
   localparam logic [1:0] SEL_X = 2'd2;

   // Adder operation (ADD_SUBT)
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Moore outputs, all a pure function of the main state
   typedef struct packed {
      logic       ms_1;
      logic       en_reg3;
      logic [1:0] ms_4;
      logic       add_subt;
      logic       en_reg1z;
      logic [1:0] ms_2;
      logic [1:0] ms_3;
      logic       en_reg2;
      logic       clk_cdir;
      logic       en_reg2xyz;
      logic       ready;
   } moore_t;

   // States that own an adder call for their whole duration
   function automatic logic is_call_state(input state_t s);
      return (s == ST_XINIT) || (s == ST_YINIT) || (s == ST_XUPD) ||
             (s == ST_YUPD)  || (s == ST_ZUPD)  || (s == ST_FINAL);
   endfunction

   // Operand selects stay put for the entire call, so they are Moore here
   function automatic moore_t decode_moore(input state_t s);
      moore_t m;
      m = '0;
      case (s)
         ST_LOAD_T: m.en_reg3 = 1'b1;
         ST_XINIT:  begin m.ms_4 = PAIR_INIT;  m.add_subt = OP_ADD; end
         ST_YINIT:  begin m.ms_4 = PAIR_INIT;  m.add_subt = OP_SUB; end
         ST_ZINIT:  begin m.ms_1 = 1'b1;       m.en_reg1z = 1'b1;   end
         ST_SHIFT:  m.en_reg2 = 1'b1;
         ST_XSEL:   begin m.ms_2 = SEL_X;      m.en_reg2xyz = 1'b1; end
         ST_XUPD:   begin m.ms_3 = SEL_X;      m.ms_4 = PAIR_ITER;  end
         ST_YSEL:   begin m.ms_2 = SEL_Y;      m.en_reg2xyz = 1'b1; end
         ST_YUPD:   begin m.ms_3 = SEL_Y;      m.ms_4 = PAIR_ITER;  end
         ST_ZSEL:   begin m.ms_2 = SEL_Z;      m.en_reg2xyz = 1'b1; end
         ST_ZUPD:   begin m.ms_3 = SEL_Z;      m.ms_4 = PAIR_ITER;  end
         ST_STEP:   m.clk_cdir = 1'b1;
         ST_FINAL:  begin m.ms_4 = PAIR_ZLN16; m.add_subt = OP_SUB; end
         ST_DONE:   m.ready = 1'b1;
         default:   ;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_ln_ctrl_call.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_call_seq
// Description : GO / WAIT / capture / DRAIN handshaker around the shared FP
//               adder, with sticky overflow/underflow capture.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_call_seq
   import cordic_ln_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic ack_sum_i,
   input  logic of_in_i,
   input  logic uf_in_i,
   input  logic flag_clr_i,
   output logic begin_sum_o,
   output logic capture_o,
   output logic done_o,
   output logic of_o,
   output logic uf_o
);

   call_state_t cs_q, cs_d;
   logic        of_q, uf_q;

   // Next call state; a GO is never launched while the adder still acks
   always_comb begin
      cs_d = cs_q;
      case (cs_q)
         CS_IDLE:  if (req_i && !ack_sum_i) cs_d = CS_GO;
         CS_GO:    cs_d = CS_WAIT;
         CS_WAIT:  if (ack_sum_i) cs_d = CS_DRAIN;
         CS_DRAIN: if (!ack_sum_i) cs_d = CS_IDLE;
         default:  cs_d = CS_IDLE;
      endcase
   end

   // Call state and sticky flags, flags sampled only in the capture cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_q <= CS_IDLE;
         of_q <= 1'b0;
         uf_q <= 1'b0;
      end else begin
         cs_q <= cs_d;
         if (flag_clr_i) begin
            of_q <= 1'b0;
            uf_q <= 1'b0;
         end else if (capture_o) begin
            of_q <= of_q | of_in_i;
            uf_q <= uf_q | uf_in_i;
         end
      end
   end

   assign begin_sum_o = (cs_q == CS_GO);
   assign capture_o   = (cs_q == CS_WAIT) && ack_sum_i;
   assign done_o      = (cs_q == CS_DRAIN) && !ack_sum_i;
   assign of_o        = of_q;
   assign uf_o        = uf_q;

endmodule
`default_nettype wire

// File: rtl/cordic_ln_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cordic_ln_ctrl
// Description : Control FSM sequencing the natural-log CORDIC datapath:
//               init of X/Y/Z, N_ITER micro-rotations, final ln16 removal,
//               with a start/ready handshake toward the top level.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_ln_ctrl
   import cordic_ln_ctrl_pkg::*;
#(
   parameter int D      = 5,
   parameter int N_ITER = 25
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         BEG_FSM_CORDIC,
   input  logic         ACK_FSM_CORDIC,
   input  logic         ACK_SUM,
   input  logic         O_F_IN,
   input  logic         U_F_IN,
   input  logic [D-1:0] CONT_ITERA,
   output logic         RST_DP,
   output logic         MS_1,
   output logic         EN_REG3,
   output logic         EN_REG4,
   output logic [1:0]   MS_4,
   output logic         ADD_SUBT,
   output logic         Begin_SUM,
   output logic         EN_REG1X,
   output logic         EN_REG1Y,
   output logic         EN_REG1Z,
   output logic [1:0]   MS_2,
   output logic [1:0]   MS_3,
   output logic         EN_REG2,
   output logic         CLK_CDIR,
   output logic         EN_REG2XYZ,
   output logic         READY,
   output logic         O_F,
   output logic         U_F
);

   localparam logic [D-1:0] LAST_ITER = D'(N_ITER - 1);

   state_t state_q, state_d;
   moore_t out_q, out_d;

   logic w_call_req;
   logic w_call_cap;
   logic w_call_done;
   logic w_last_iter;

   assign w_call_req  = is_call_state(state_q);
   assign w_last_iter = (CONT_ITERA == LAST_ITER);

   fp_add_call_seq u_call (
      .clk         (CLK),
      .rst         (RST),
      .req_i       (w_call_req),
      .ack_sum_i   (ACK_SUM),
      .of_in_i     (O_F_IN),
      .uf_in_i     (U_F_IN),
      .flag_clr_i  (state_q == ST_CLR),
      .begin_sum_o (Begin_SUM),
      .capture_o   (w_call_cap),
      .done_o      (w_call_done),
      .of_o        (O_F),
      .uf_o        (U_F)
   );

   // Next-state sequencing; call states advance only once the adder drained
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (BEG_FSM_CORDIC) state_d = ST_CLR;
         ST_CLR:    state_d = ST_LOAD_T;
         ST_LOAD_T: state_d = ST_XINIT;
         ST_XINIT:  if (w_call_done) state_d = ST_YINIT;
         ST_YINIT:  if (w_call_done) state_d = ST_ZINIT;
         ST_ZINIT:  state_d = ST_SETTLE;
         ST_SETTLE: state_d = ST_SHIFT;
         ST_SHIFT:  state_d = ST_XSEL;
         ST_XSEL:   state_d = ST_XUPD;
         ST_XUPD:   if (w_call_done) state_d = ST_YSEL;
         ST_YSEL:   state_d = ST_YUPD;
         ST_YUPD:   if (w_call_done) state_d = ST_ZSEL;
         ST_ZSEL:   state_d = ST_ZUPD;
         ST_ZUPD:   if (w_call_done) state_d = w_last_iter ? ST_FINAL : ST_STEP;
         ST_STEP:   state_d = ST_SETTLE;
         ST_FINAL:  if (w_call_done) state_d = ST_DONE;
         ST_DONE:   if (ACK_FSM_CORDIC) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      out_d = decode_moore(state_d);
   end

   // State and registered Moore outputs; out_q always equals decode(state_q)
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign RST_DP     = RST | (state_q == ST_CLR);
   assign MS_1       = out_q.ms_1;
   assign EN_REG3    = out_q.en_reg3;
   assign MS_4       = out_q.ms_4;
   assign ADD_SUBT   = out_q.add_subt;
   assign MS_2       = out_q.ms_2;
   assign MS_3       = out_q.ms_3;
   assign EN_REG2    = out_q.en_reg2;
   assign CLK_CDIR   = out_q.clk_cdir;
   assign EN_REG2XYZ = out_q.en_reg2xyz;
   assign READY      = out_q.ready;

   // Capture enables carry the Mealy ACK term from the handshaker
   assign EN_REG1X = w_call_cap & ((state_q == ST_XINIT) | (state_q == ST_XUPD));
   assign EN_REG1Y = w_call_cap & ((state_q == ST_YINIT) | (state_q == ST_YUPD));
   assign EN_REG1Z = out_q.en_reg1z | (w_call_cap & (state_q == ST_ZUPD));
   assign EN_REG4  = w_call_cap & (state_q == ST_FINAL);

endmodule
`default_nettype wire

// File: tb/tb_cordic_ln_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_ln_ctrl
// Description : Self-checking bench for cordic_ln_ctrl with an adder stub
//               and iteration-counter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_ln_ctrl;

   localparam int D       = 5;
   localparam int N_ITER  = 25;
   localparam int N_CALLS = 3 * N_ITER + 3;
   localparam int BUDGET  = 20000;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic BEG_FSM_CORDIC = 1'b0;
   logic ACK_FSM_CORDIC = 1'b0;
   logic ACK_SUM = 1'b0;
   logic O_F_IN = 1'b0;
   logic U_F_IN = 1'b0;
   logic [D-1:0] cont_q = '0;
   wire  [D-1:0] CONT_ITERA;

   wire       RST_DP, MS_1, EN_REG3, EN_REG4, ADD_SUBT, Begin_SUM;
   wire       EN_REG1X, EN_REG1Y, EN_REG1Z, EN_REG2, CLK_CDIR, EN_REG2XYZ;
   wire       READY, O_F, U_F;
   wire [1:0] MS_4, MS_2, MS_3;

   cordic_ln_ctrl #(.D(D), .N_ITER(N_ITER)) dut (
      .CLK(CLK), .RST(RST), .BEG_FSM_CORDIC(BEG_FSM_CORDIC),
      .ACK_FSM_CORDIC(ACK_FSM_CORDIC), .ACK_SUM(ACK_SUM), .O_F_IN(O_F_IN),
      .U_F_IN(U_F_IN), .CONT_ITERA(CONT_ITERA), .RST_DP(RST_DP), .MS_1(MS_1),
      .EN_REG3(EN_REG3), .EN_REG4(EN_REG4), .MS_4(MS_4), .ADD_SUBT(ADD_SUBT),
      .Begin_SUM(Begin_SUM), .EN_REG1X(EN_REG1X), .EN_REG1Y(EN_REG1Y),
      .EN_REG1Z(EN_REG1Z), .MS_2(MS_2), .MS_3(MS_3), .EN_REG2(EN_REG2),
      .CLK_CDIR(CLK_CDIR), .EN_REG2XYZ(EN_REG2XYZ), .READY(READY),
      .O_F(O_F), .U_F(U_F)
   );

   always #5 CLK = ~CLK;

   wire [18:0] all_ctl = {RST_DP, MS_1, EN_REG3, EN_REG4, MS_4, ADD_SUBT, Begin_SUM,
                          EN_REG1X, EN_REG1Y, EN_REG1Z, MS_2, MS_3, EN_REG2,
                          CLK_CDIR, EN_REG2XYZ, READY};
   wire [20:0] all_out = {all_ctl, O_F, U_F};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Datapath iteration counter
   always @(posedge CLK) begin
      if (RST_DP)        cont_q <= '0;
      else if (CLK_CDIR) cont_q <= cont_q + 1'b1;
   end
   assign CONT_ITERA = cont_q;

   // Adder stub: latency 3 after Begin_SUM, ACK held ack_hold cycles
   int ack_hold = 1;
   int of_call  = -1;
   int uf_call  = -1;
   int stub_call = 0, stub_cur = 0, lat = 0, hold = 0;

   always @(posedge CLK) begin
      if (RST) begin
         lat <= 0; hold <= 0; stub_call <= 0;
         ACK_SUM <= 1'b0; O_F_IN <= 1'b0; U_F_IN <= 1'b0;
      end else begin
         if (RST_DP) stub_call <= 0;
         if (Begin_SUM) begin
            lat       <= 3;
            stub_cur  <= stub_call;
            stub_call <= stub_call + 1;
         end else if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
               ACK_SUM <= 1'b1;
               hold    <= ack_hold;
               O_F_IN  <= (stub_cur == of_call);
               U_F_IN  <= (stub_cur == uf_call);
            end
         end else if (hold != 0) begin
            hold   <= hold - 1;
            O_F_IN <= 1'b0;
            U_F_IN <= 1'b0;
            if (hold == 1) ACK_SUM <= 1'b0;
         end
      end
   end

   // Expected adder call: MS_4, op, destination (0 X,1 Y,2 Z,3 result), MS_3
   typedef struct packed {
      logic [1:0] ms4;
      logic       op;
      logic [1:0] dest;
      logic [1:0] ms3;
   } call_t;

   function automatic call_t mk(input int ms4, input int op, input int dest, input int ms3);
      call_t c;
      c.ms4 = ms4[1:0]; c.op = op[0]; c.dest = dest[1:0]; c.ms3 = ms3[1:0];
      return c;
   endfunction

   function automatic call_t exp_call(input int idx);
      if (idx == 0)           return mk(2, 0, 0, 0);
      if (idx == 1)           return mk(2, 1, 1, 0);
      if (idx == N_CALLS - 1) return mk(0, 1, 3, 0);
      if (idx >= N_CALLS)     return mk(3, 1, 3, 3);
      case ((idx - 2) % 3)
         0:       return mk(1, 0, 0, 2);
         1:       return mk(1, 0, 1, 1);
         default: return mk(1, 0, 2, 0);
      endcase
   endfunction

   call_t sb_q[$];
   int call_idx = 0;
   int cnt_begin = 0, cnt_cdir = 0, cnt_rstdp = 0, cnt_reg4 = 0, cnt_zinit = 0;
   int n_cap;
   int act_dest;
   call_t e;

   // Output monitor and scoreboard
   always @(negedge CLK) begin
      if (RST) begin
         sb_q.delete();
         call_idx = 0;
      end else begin
         if (RST_DP) begin
            cnt_rstdp++;
            call_idx = 0;
         end
         if (CLK_CDIR) cnt_cdir++;
         if (EN_REG1Z && MS_1) cnt_zinit++;
         if (Begin_SUM) begin
            chk("begin_while_ack", ACK_SUM, 0);
            sb_q.push_back(exp_call(call_idx));
            call_idx++;
            cnt_begin++;
         end
         n_cap = int'(EN_REG1X) + int'(EN_REG1Y) + int'(EN_REG1Z && !MS_1) + int'(EN_REG4);
         if (n_cap != 0) begin
            chk("cap_onehot", n_cap, 1);
            chk("cap_ack", ACK_SUM, 1);
            chk("sb_pending", sb_q.size(), 1);
            act_dest = EN_REG1X ? 0 : EN_REG1Y ? 1 : (EN_REG1Z && !MS_1) ? 2 : 3;
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk("cap_dest", act_dest, e.dest);
               chk("cap_ms4", MS_4, e.ms4);
               chk("cap_op", ADD_SUBT, e.op);
               chk("cap_ms3", MS_3, e.ms3);
            end
            if (EN_REG4) begin
               cnt_reg4++;
               chk("final_cont", CONT_ITERA, N_ITER - 1);
            end
         end
      end
   end

   typedef struct {
      int ack_hold;
      int of_call;
      int uf_call;
      int exp_cdir;
      int exp_begin;
      int exp_of;
      int exp_uf;
   } vec_t;

   task automatic run_op(input vec_t v, input int idx);
      int b0, c0, r0, e0, z0, n;
      ack_hold = v.ack_hold; of_call = v.of_call; uf_call = v.uf_call;
      b0 = cnt_begin; c0 = cnt_cdir; r0 = cnt_rstdp; e0 = cnt_reg4; z0 = cnt_zinit;
      @(posedge CLK); #1 BEG_FSM_CORDIC = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("v%0d_clr_rst_dp", idx), RST_DP, 1);
      BEG_FSM_CORDIC = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_clr_of", idx), O_F, 0);
      chk($sformatf("v%0d_clr_uf", idx), U_F, 0);
      chk($sformatf("v%0d_cont0", idx), CONT_ITERA, 0);
      chk($sformatf("v%0d_load_t", idx), EN_REG3, 1);
      n = 0;
      while (!READY && n < BUDGET) begin
         @(negedge CLK);
         n++;
      end
      chk($sformatf("v%0d_ready_timeout", idx), READY, 1);
      chk($sformatf("v%0d_cdir", idx), cnt_cdir - c0, v.exp_cdir);
      chk($sformatf("v%0d_begin", idx), cnt_begin - b0, v.exp_begin);
      chk($sformatf("v%0d_reg4", idx), cnt_reg4 - e0, 1);
      chk($sformatf("v%0d_rstdp", idx), cnt_rstdp - r0, 1);
      chk($sformatf("v%0d_zinit", idx), cnt_zinit - z0, 1);
      chk($sformatf("v%0d_of", idx), O_F, v.exp_of);
      chk($sformatf("v%0d_uf", idx), U_F, v.exp_uf);
      repeat (3) @(negedge CLK);
      chk($sformatf("v%0d_ready_held", idx), READY, 1);
      chk($sformatf("v%0d_of_held", idx), O_F, v.exp_of);
      @(posedge CLK); #1 ACK_FSM_CORDIC = 1'b1;
      @(posedge CLK); #1 ACK_FSM_CORDIC = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_ready_drop", idx), READY, 0);
      chk($sformatf("v%0d_idle_ctl", idx), all_ctl, 0);
      chk($sformatf("v%0d_idle_uf", idx), U_F, v.exp_uf);
   endtask

   vec_t vecs[6];
   int   n, seen, r0, b0, c0;

   initial begin
      vecs[0] = '{1, -1, -1, N_ITER - 1, N_CALLS, 0, 0};
      vecs[1] = '{3, -1, -1, N_ITER - 1, N_CALLS, 0, 0};
      vecs[2] = '{1, 30, -1, N_ITER - 1, N_CALLS, 1, 0};
      vecs[3] = '{2, -1, 77, N_ITER - 1, N_CALLS, 0, 1};
      vecs[4] = '{1,  0, 40, N_ITER - 1, N_CALLS, 1, 1};
      vecs[5] = '{1, -1, -1, N_ITER - 1, N_CALLS, 0, 0};

      // Power-on reset
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_rst_dp", RST_DP, 1);
      chk("reset_ready", READY, 0);
      chk("reset_flags", {O_F, U_F}, 0);
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      chk("reset_idle_outputs", all_out, 0);

      for (int i = 0; i < 6; i++) run_op(vecs[i], i);

      // Reset during the 10th iteration
      ack_hold = 1; of_call = 5; uf_call = -1;
      @(posedge CLK); #1 BEG_FSM_CORDIC = 1'b1;
      @(posedge CLK); #1 BEG_FSM_CORDIC = 1'b0;
      n = 0;
      while (CONT_ITERA != 5'd9 && n < BUDGET) begin
         @(negedge CLK);
         n++;
      end
      chk("rst_reach_iter10", CONT_ITERA, 9);
      repeat (6) @(negedge CLK);
      chk("rst_of_before", O_F, 1);
      @(posedge CLK); #1 RST = 1'b1;
      @(negedge CLK);
      chk("rst_dp_follows_rst", RST_DP, 1);
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_all_idle", all_out, 0);
      repeat (3) @(negedge CLK);
      chk("rst_stays_idle", all_out, 0);
      run_op(vecs[0], 10);

      // Start held high continuously: back-to-back operations
      ack_hold = 1; of_call = -1; uf_call = -1;
      r0 = cnt_rstdp; b0 = cnt_begin; c0 = cnt_cdir;
      @(posedge CLK); #1 BEG_FSM_CORDIC = 1'b1; ACK_FSM_CORDIC = 1'b1;
      n = 0; seen = 0;
      while (seen < 2 && n < 2 * BUDGET) begin
         @(negedge CLK);
         n++;
         if (READY) seen++;
      end
      BEG_FSM_CORDIC = 1'b0;
      chk("b2b_done_count", seen, 2);
      @(posedge CLK); #1 ACK_FSM_CORDIC = 1'b0;
      repeat (3) @(negedge CLK);
      chk("b2b_rstdp", cnt_rstdp - r0, 2);
      chk("b2b_begin", cnt_begin - b0, 2 * N_CALLS);
      chk("b2b_cdir", cnt_cdir - c0, 2 * (N_ITER - 1));
      chk("b2b_idle", all_ctl, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cordic_ln_ctrl.md
Name: cordic_ln_ctrl

Overview:
- Control FSM that sequences the natural-logarithm CORDIC coprocessor datapath.
- The datapath is the responder. It holds the X/Y/Z registers, the shift/arctanh LUTs, the iteration counter and the shared FP add/subtract unit.
- This block is the initiator. It drives every mux select, register enable, adder start and counter-step strobe, and consumes ACK_SUM, the overflow/underflow flags and CONT_ITERA.
- It gives the top level a start/ready handshake.

Parameters:
- D, 5, width of the iteration counter.
- N_ITER, 25, number of hyperbolic CORDIC micro-rotations (1..2^D-1). The LUT already contains the repeated indices.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- BEG_FSM_CORDIC  in  1  start request, level-sampled in IDLE
- ACK_FSM_CORDIC  in  1  top-level acknowledge of RESULT
- ACK_SUM  in  1  FP adder ready; the adder self-clears it one cycle after assertion
- O_F_IN  in  1  adder overflow flag
- U_F_IN  in  1  adder underflow flag
- CONT_ITERA  in  D  datapath iteration count
- RST_DP  out  1  datapath register/counter clear
- MS_1  out  1  Z-init select (1 = zero)
- EN_REG3  out  1  latch 16·T
- EN_REG4  out  1  latch final result
- MS_4  out  2  adder operand pair (0 = Z/ln16, 1 = XYZ/shifted, 2 = 16T/1.0)
- ADD_SUBT  out  1  0 = add, 1 = subtract
- Begin_SUM  out  1  adder start pulse
- EN_REG1X  out  1  X register enable
- EN_REG1Y  out  1  Y register enable
- EN_REG1Z  out  1  Z register enable
- MS_2  out  2  previous-value select (0 = Z, 1 = Y, 2 = X)
- MS_3  out  2  shifted-value select (0 = Z, 1 = Y, 2 = X)
- EN_REG2  out  1  latch shifted X/Y and LUT Z
- CLK_CDIR  out  1  iteration counter step
- EN_REG2XYZ  out  1  latch previous operand
- READY  out  1  result valid
- O_F  out  1  sticky overflow
- U_F  out  1  sticky underflow

Behaviour:
- Reset and idle values:
  - RST asserted: state IDLE, O_F = U_F = 0, READY = 0.
  - RST_DP = RST OR (state == CLR).
  - All other outputs 0: selects 0, enables 0, strobes 0. These are also their values in every state not naming them.
- All outputs are Moore, decoded from the state register. The adder-call waits add a Mealy ACK term to the capture enable.
- Adder call, CALL(sel, op, dest):
  - GO: one cycle with Begin_SUM = 1; MS_4 = sel and ADD_SUBT = op held from GO to capture.
  - WAIT: remain while ACK_SUM = 0.
  - Capture: in the cycle ACK_SUM = 1, assert the dest enable.
  - DRAIN: wait for ACK_SUM = 0 before the next GO. A new Begin_SUM is never issued while ACK_SUM = 1.
- State sequence:
  - IDLE: when BEG_FSM_CORDIC = 1, go to CLR.
  - CLR: RST_DP = 1 for one cycle; counter goes to 0.
  - LOAD_T: EN_REG3 = 1.
  - XINIT: CALL(2, add, EN_REG1X), giving X = 16T + 1.
  - YINIT: CALL(2, sub, EN_REG1Y), giving Y = 16T − 1.
  - ZINIT: MS_1 = 1, EN_REG1Z = 1, giving Z = 0.
  - SETTLE: one cycle for the synchronous LUT outputs.
  - SHIFT: EN_REG2 = 1.
  - XSEL: MS_2 = 2, EN_REG2XYZ = 1. Then XUPD: MS_3 = 2, CALL(1, add, EN_REG1X).
  - YSEL: MS_2 = 1, EN_REG2XYZ = 1. Then YUPD: MS_3 = 1, CALL(1, add, EN_REG1Y).
  - ZSEL: MS_2 = 0, EN_REG2XYZ = 1. Then ZUPD: MS_3 = 0, MS_1 = 0, CALL(1, add, EN_REG1Z).
  - Rotation direction is folded into operand signs by the datapath, so ADD_SUBT stays 0 for all updates.
  - After ZUPD DRAIN: if CONT_ITERA == N_ITER−1, go to FINAL. Otherwise STEP: CLK_CDIR = 1 for one cycle, then SETTLE.
  - FINAL: CALL(0, sub, EN_REG4), giving RESULT = Z − ln16 = ln T.
  - DONE: READY = 1, held until ACK_FSM_CORDIC = 1, then IDLE.
- Counts: exactly N_ITER−1 CLK_CDIR pulses per operation. Latency = fixed overhead + (3·N_ITER + 3) adder calls.
- Flags:
  - O_F / U_F set when O_F_IN / U_F_IN is high in a capture cycle.
  - Both clear in CLR.
  - Both held through DONE.
- Start handling:
  - BEG_FSM_CORDIC is ignored outside IDLE.
  - If it is still high when DONE exits, a new operation starts only after IDLE samples it.
- Reset mid-operation: RST wins in any state; next cycle is IDLE with all outputs inactive.

Decomposition:
- Shared package: state encoding enum; MS_4 pair codes (PAIR_ZLN16 = 0, PAIR_ITER = 1, PAIR_INIT = 2); XYZ select codes (SEL_Z = 0, SEL_Y = 1, SEL_X = 2); ADD/SUB constants.
- One sub-module, fp_add_call_seq:
  - Generic GO/WAIT/capture/DRAIN handshaker with req/done and sticky flag capture.
  - Instantiated once; the main FSM sets sel/op/dest around it.

Test Plan:
- Adder stub, latency 3, ACK held 1 cycle; T = 0x3F800000 (1.0), N_ITER = 25 -> exactly 24 CLK_CDIR pulses, 3·25+3 = 78 Begin_SUM pulses, READY with EN_REG4 captured once; real datapath RESULT within 4 ulp of 0x00000000.
- T = 0x402DF854 (e), real datapath -> RESULT within 4 ulp of 0x3F800000; READY held until ACK_FSM_CORDIC, then IDLE.
- Stub with ACK_SUM held high 3 cycles -> no Begin_SUM while ACK_SUM = 1; each capture enable asserted exactly once per call.
- RST pulsed during the 10th iteration -> next cycle all outputs 0, state IDLE; a new start issues RST_DP and restarts at CONT_ITERA = 0.
- O_F_IN high at one iteration capture -> O_F = 1 through DONE; cleared by the next operation's CLR.
- BEG_FSM_CORDIC held high continuously -> back-to-back operations, each preceded by exactly one RST_DP cycle.
